// File: rtl/result_writer.sv
// result_writer: streams one NDWORDS-dword record to an AVMM slave as 16-bit beats,
// low half of each dword first, starting at base + index*record_size.
module result_writer #(
    parameter int NDWORDS = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [31:0]             i_baseaddr,
    input  logic [31:0]             i_index,
    input  logic                    i_write,
    input  logic [32*NDWORDS-1:0]   i_data,
    output logic                    o_ready,
    output logic                    o_done,
    output logic                    avm_m0_write,
    output logic [31:0]             avm_m0_address,
    output logic [15:0]             avm_m0_writedata,
    output logic [1:0]              avm_m0_byteenable,
    input  logic                    avm_m0_waitrequest
);
    localparam int NBEATS = 2 * NDWORDS;
    localparam int BW = $clog2(NBEATS);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [32*NDWORDS-1:0] data_q, data_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  done_q, done_d;
    logic                  accept, beat_done, last_beat;

    assign accept    = i_write && (state_q == IDLE);
    assign beat_done = (state_q == WRITE) && !avm_m0_waitrequest;
    assign last_beat = beat_q == BW'(NBEATS - 1);

    // The payload register shifts down one halfword per completed beat, so
    // the beat in flight always sits in the low 16 bits.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        if (accept) begin
            state_d = WRITE;
            addr_d  = i_baseaddr + i_index * 32'(4 * NDWORDS);
            data_d  = i_data;
            beat_d  = '0;
        end else if (beat_done) begin
            state_d = last_beat ? IDLE : WRITE;
            done_d  = last_beat;
            addr_d  = addr_q + 32'd2;
            data_d  = data_q >> 16;
            beat_d  = beat_q + BW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    assign o_ready           = state_q == IDLE;
    assign o_done            = done_q;
    assign avm_m0_write      = state_q == WRITE;
    assign avm_m0_address    = addr_q;
    assign avm_m0_writedata  = data_q[15:0];
    assign avm_m0_byteenable = {2{avm_m0_write}};
endmodule

// File: tb/tb_result_writer.sv
// tb_result_writer: directed scenarios plus randomized traffic against a beat-queue reference model.
module tb_result_writer;
    localparam int N  = 3;
    localparam int NB = 2 * N;

    logic            clk = 1'b0;
    logic            rstn;
    logic [31:0]     base, idx;
    logic            wr;
    logic [32*N-1:0] data;
    logic            ready, done, avm_write, waitreq;
    logic [31:0]     avm_addr;
    logic [15:0]     avm_data;
    logic [1:0]      avm_be;

    int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, stalls = 0;
    logic [47:0] beats[$];
    bit exp_done = 1'b0, exp_rst = 1'b0;

    always #5 clk = ~clk;

    result_writer #(.NDWORDS(N)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_baseaddr(base), .i_index(idx), .i_write(wr),
        .i_data(data), .o_ready(ready), .o_done(done), .avm_m0_write(avm_write),
        .avm_m0_address(avm_addr), .avm_m0_writedata(avm_data),
        .avm_m0_byteenable(avm_be), .avm_m0_waitrequest(waitreq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: an accepted record becomes a queue of {address, halfword} beats;
    // the bus must present the queue head until it is taken without waitrequest.
    task automatic model();
        logic [31:0] start;
        check("done", done, exp_done);
        if (exp_done && done) check("latency", cyc - acc_cyc, NB + 1 + stalls);
        if (exp_rst) begin
            check("rst_addr", avm_addr, 0);
            check("rst_data", avm_data, 0);
            check("rst_be", avm_be, 0);
        end
        exp_rst  = 1'b0;
        exp_done = 1'b0;
        if (!rstn) begin
            beats.delete();
            exp_rst = 1'b1;
        end else if (beats.size() != 0) begin
            check("busy_write", avm_write, 1);
            check("busy_ready", ready, 0);
            check("busy_be", avm_be, 2'b11);
            check("beat_addr", avm_addr, beats[0][47:16]);
            check("beat_data", avm_data, beats[0][15:0]);
            if (waitreq) stalls++;
            else begin
                void'(beats.pop_front());
                if (beats.size() == 0) exp_done = 1'b1;
            end
        end else begin
            check("idle_write", avm_write, 0);
            check("idle_ready", ready, 1);
            check("idle_be", avm_be, 0);
            if (wr) begin
                start = 32'((64'(base) + 64'(idx) * N * 4) % 64'h1_0000_0000);
                for (int b = 0; b < NB; b++) beats.push_back({start + 32'(2 * b), data[16*b +: 16]});
                acc_cyc = cyc;
                stalls  = 0;
            end
        end
    endtask

    task automatic tick();
        model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic scramble();
        base = $urandom;
        idx  = $urandom;
        for (int k = 0; k < N; k++) data[32*k +: 32] = $urandom;
    endtask

    task automatic request(input logic [31:0] b, input logic [31:0] i, input logic [32*N-1:0] d);
        base = b;
        idx  = i;
        data = d;
        wr   = 1'b1;
        tick();
        wr = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    logic [32*N-1:0] rec;

    initial begin
        rstn = 1'b0; wr = 1'b1; waitreq = 1'b0;
        scramble();
        @(posedge clk);
        #1;
        repeat (3) tick();
        rstn = 1'b1; wr = 1'b0;
        tick();
        rec = {32'h55556666, 32'h33334444, 32'h11112222};
        // basic write
        request(32'h1000, 2, rec);
        check("basic_addr0", avm_addr, 32'h1018);
        check("basic_data0", avm_data, 16'h2222);
        tick();
        check("basic_addr1", avm_addr, 32'h101A);
        check("basic_data1", avm_data, 16'h1111);
        wait_done(20);
        tick();
        // backpressure on beat 1
        request(32'h1000, 2, rec);
        tick();
        waitreq = 1'b1;
        repeat (3) tick();
        waitreq = 1'b0;
        wait_done(20);
        tick();
        // busy request ignored
        request(32'h1000, 2, rec);
        tick();
        tick();
        wr = 1'b1; idx = 5;
        tick();
        wr = 1'b0;
        wait_done(20);
        tick();
        check("busy_no_extra", avm_write, 0);
        // back-to-back from the done cycle
        request(32'h1000, 2, rec);
        wait_done(20);
        request(32'h1000, 3, rec);
        check("b2b_addr0", avm_addr, 32'h1024);
        wait_done(20);
        tick();
        // mid-record reset
        request(32'h1000, 2, rec);
        repeat (3) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("rst_write", avm_write, 0);
        check("rst_ready", ready, 1);
        tick();
        request(32'h1000, 2, rec);
        wait_done(20);
        tick();
        // address wrap
        request(32'hFFFF_FFF8, 0, rec);
        check("wrap_addr0", avm_addr, 32'hFFFF_FFF8);
        repeat (4) tick();
        check("wrap_addr4", avm_addr, 32'h0000_0000);
        wait_done(20);
        tick();
        // randomized traffic
        for (int t = 0; t < 600; t++) begin
            wr      = $urandom_range(0, 3) == 0;
            waitreq = $urandom_range(0, 3) == 0;
            rstn    = $urandom_range(0, 59) != 0;
            scramble();
            if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            if ($urandom_range(0, 1) == 0) idx = $urandom_range(0, 15);
            tick();
        end
        rstn = 1'b1; wr = 1'b0; waitreq = 1'b0;
        repeat (NB + 4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 SHALL have parameter NDWORDS, default 3, giving the number of 32-bit dwords per record; legal range is 1..64.
REQ-002 SHALL have port i_clk, input, 1 bit: clock; all logic is rising-edge.
REQ-003 SHALL have port i_rstn, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port i_baseaddr, input, 32 bits: byte base address of the record array; sampled on accept.
REQ-005 SHALL have port i_index, input, 32 bits: record index; sampled on accept.
REQ-006 SHALL have port i_write, input, 1 bit: request to write one record.
REQ-007 SHALL have port i_data, input, 32*NDWORDS bits: record payload; dword k is i_data[32k+31:32k]; sampled on accept.
REQ-008 SHALL have port o_ready, output, 1 bit: high when a request can be accepted.
REQ-009 SHALL have port o_done, output, 1 bit: one-cycle pulse when the record is fully written.
REQ-010 SHALL have port avm_m0_write, output, 1 bit: AVMM write strobe.
REQ-011 SHALL have port avm_m0_address, output, 32 bits: AVMM byte address.
REQ-012 SHALL have port avm_m0_writedata, output, 16 bits: AVMM write data.
REQ-013 SHALL have port avm_m0_byteenable, output, 2 bits: AVMM byte enables.
REQ-014 SHALL have port avm_m0_waitrequest, input, 1 bit: slave stall.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, WRITE.
REQ-016 In IDLE, o_ready SHALL be 1 and avm_m0_write SHALL be 0; in WRITE, o_ready SHALL be 0.
REQ-017 A request SHALL be accepted when i_write=1 and o_ready=1 on a rising edge; the FSM then enters WRITE and avm_m0_write=1 on the next cycle.
REQ-018 i_write while in WRITE SHALL be ignored; it SHALL NOT be queued.
REQ-019 The record start address SHALL be i_baseaddr + i_index*NDWORDS*4, computed modulo 2^32.
REQ-020 Each record SHALL be written as 2*NDWORDS halfword beats, beat b = 0..2*NDWORDS-1, in ascending order.
REQ-021 Beat b SHALL carry payload bits [16b+15:16b], so each dword is sent low half first.
REQ-022 Beat b SHALL be issued at the start address + 2b.
REQ-023 avm_m0_byteenable SHALL be 2'b11 whenever avm_m0_write=1, and 2'b00 otherwise.
REQ-024 A beat SHALL complete on a cycle where avm_m0_write=1 and avm_m0_waitrequest=0; while waitrequest=1, address, writedata and byteenable SHALL be held stable.
REQ-025 After a non-final beat completes, the next beat SHALL be presented in the immediately following cycle, with no idle cycle between beats.
REQ-026 When the final beat completes, the FSM SHALL return to IDLE.
REQ-027 When the final beat completes, o_done SHALL be 1 for exactly the next cycle, coincident with o_ready=1.
REQ-028 A new request accepted in the cycle o_done=1 SHALL be honored.
REQ-029 Minimum latency from accept to o_done SHALL be 2*NDWORDS+1 cycles, with waitrequest held 0 throughout.
REQ-030 The accepted payload, address and beat counter SHALL be held in internal registers, so later changes on inputs SHALL NOT affect an in-flight record.

Reset
REQ-031 When i_rstn=0 at a rising edge, the FSM SHALL go to IDLE.
REQ-032 During reset, o_ready SHALL be 1 and o_done, avm_m0_write, avm_m0_address, avm_m0_writedata and avm_m0_byteenable SHALL all be 0 from the next cycle.
REQ-033 Reset mid-record SHALL abandon the remaining beats; no o_done SHALL be produced for the abandoned record.
REQ-034 i_write SHALL be ignored while i_rstn=0.

Verification
REQ-035 Basic write: NDWORDS=3, base=0x1000, index=2, data dwords {0x11112222, 0x33334444, 0x55556666} (dword0 first), waitrequest=0 -> six beats at addresses 0x1018..0x1022 step 2 with data 2222, 1111, 4444, 3333, 6666, 5555; o_done exactly 7 cycles after accept.
REQ-036 Backpressure: waitrequest=1 for 3 cycles on beat 1 -> beat 1 address and data are held stable for 4 cycles; all six beats are still written in order; o_done is 3 cycles later than in REQ-035.
REQ-037 Busy request: pulse i_write mid-record with index=5 -> ignored, no extra beats, and exactly one o_done.
REQ-038 Back-to-back: i_write asserted in the o_done cycle with index=3 -> the second record starts at 0x1024 immediately after.
REQ-039 Mid-record reset: assert reset after beat 2 -> next cycle avm_m0_write=0, o_ready=1 and no o_done; a following request writes all six beats normally.
REQ-040 Address wrap: base=0xFFFFFFF8, index=0 -> beat addresses 0xFFFFFFF8, FFFFFFFA, FFFFFFFC, FFFFFFFE, 0x00000000, 0x00000002.
